// File: rtl/gate_truth_checker_if.sv
// gate_truth_checker_if: stimulus/response bundle between the checker and its gate under test
interface gate_truth_checker_if;
  logic       start;
  logic       A;
  logic       B;
  logic       Y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  modport master (output start, Y, input A, B, busy, done, pass, err_count, fail_vec);
  modport slave  (input start, Y, output A, B, busy, done, pass, err_count, fail_vec);
endinterface

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps all four {A,B} vectors and compares Y against a truth table
module gate_truth_checker #(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         SETTLE = 2
) (
  input logic             clk,
  input logic             rst,
  gate_truth_checker_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic       busy, done, pass;
  logic [2:0] err;
  logic [3:0] fv;
  logic       mis;
  assign mis           = bus.Y != TRUTH[idx];
  assign bus.A         = idx[1];
  assign bus.B         = idx[0];
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.err_count = err;
  assign bus.fail_vec  = fv;
  // sweep sequencer: hold each vector SETTLE cycles, sample Y on the last one, accumulate results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      err   <= '0;
      fv    <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        state <= WAIT;
        idx   <= '0;
        cnt   <= 4'(SETTLE);
        busy  <= 1'b1;
        pass  <= 1'b0;
        err   <= '0;
        fv    <= '0;
      end
    end else if (state == WAIT) begin
      if (cnt == 4'd1) begin
        if (mis) begin
          err     <= err + 3'd1;
          fv[idx] <= 1'b1;
        end
        if (idx == 2'd3) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= !mis && err == 3'd0;
        end else begin
          idx <= idx + 2'd1;
          cnt <= 4'(SETTLE);
        end
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: random and directed gate sweeps against a truth-table reference model
module tb_gate_truth_checker;
  logic       clk = 0;
  logic       rst = 0;
  int         errors = 0;
  int         checks = 0;
  logic [3:0] devs [2];
  logic       st [2];
  logic       a [2], b [2], bz [2], dn [2], ps [2];
  logic [2:0] ec [2];
  logic [3:0] fvv [2];
  gate_truth_checker_if i0 ();
  gate_truth_checker_if i1 ();
  gate_truth_checker #(.TRUTH(4'b1000), .SETTLE(2)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  gate_truth_checker #(.TRUTH(4'b0111), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  always #5 clk = ~clk;
  assign i0.start = st[0];
  assign i1.start = st[1];
  assign i0.Y = devs[0][{i0.A, i0.B}];
  assign i1.Y = devs[1][{i1.A, i1.B}];
  assign a[0] = i0.A;  assign b[0] = i0.B;  assign bz[0] = i0.busy;  assign dn[0] = i0.done;
  assign ps[0] = i0.pass;  assign ec[0] = i0.err_count;  assign fvv[0] = i0.fail_vec;
  assign a[1] = i1.A;  assign b[1] = i1.B;  assign bz[1] = i1.busy;  assign dn[1] = i1.done;
  assign ps[1] = i1.pass;  assign ec[1] = i1.err_count;  assign fvv[1] = i1.fail_vec;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic results(input int u, input logic [3:0] dev);
    logic [3:0] truth;
    logic [3:0] miss;
    truth = u ? 4'b0111 : 4'b1000;
    miss  = dev ^ truth;
    chk("err_count", 8'(ec[u]), 8'($countones(miss)));
    chk("fail_vec", 8'(fvv[u]), 8'(miss));
    chk("pass", 8'(ps[u]), 8'(miss == 4'b0));
  endtask
  task automatic sweep(input int u, input logic [3:0] dev);
    int s;
    s = u ? 1 : 2;
    devs[u] = dev;
    @(negedge clk);
    rst = 0;
    st[u] = 1;
    tick();
    st[u] = 0;
    for (int k = 0; k < 4 * s; k++) begin
      chk("ab", 8'({a[u], b[u]}), 8'(k / s));
      chk("busy", 8'(bz[u]), 8'd1);
      chk("done_early", 8'(dn[u]), 8'd0);
      tick();
    end
    chk("done", 8'(dn[u]), 8'd1);
    chk("busy_done", 8'(bz[u]), 8'd0);
    results(u, dev);
    tick();
    chk("done_pulse", 8'(dn[u]), 8'd0);
    chk("ab_hold", 8'({a[u], b[u]}), 8'd3);
    results(u, dev);
  endtask
  initial begin
    devs[0] = 4'b0; devs[1] = 4'b0;
    st[0] = 0; st[1] = 0;
    #1 rst = 1;
    #1;
    chk("rst_ab", 8'({a[0], b[0]}), 8'd0);
    chk("rst_busy", 8'(bz[0]), 8'd0);
    chk("rst_done", 8'(dn[0]), 8'd0);
    chk("rst_pass", 8'(ps[0]), 8'd0);
    chk("rst_err", 8'(ec[0]), 8'd0);
    chk("rst_fv", 8'(fvv[0]), 8'd0);
    sweep(0, 4'b1000);
    sweep(0, 4'b0000);
    sweep(0, 4'b1110);
    sweep(1, 4'b0111);
    for (int r = 0; r < 8; r++) sweep($urandom_range(0, 1), 4'($urandom_range(0, 15)));
    devs[0] = 4'b1000;
    @(negedge clk);
    st[0] = 1;
    tick();
    st[0] = 0;
    repeat (4) tick();
    chk("mid_ab", 8'({a[0], b[0]}), 8'd2);
    #2 rst = 1;
    #1;
    chk("mid_rst_ab", 8'({a[0], b[0]}), 8'd0);
    chk("mid_rst_busy", 8'(bz[0]), 8'd0);
    chk("mid_rst_err", 8'(ec[0]), 8'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_rst_done", 8'(dn[0]), 8'd0);
    end
    sweep(0, 4'b1000);
    devs[0] = 4'b1110;
    @(negedge clk);
    st[0] = 1;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("b2b_busy1", 8'(bz[0]), 8'd1);
      chk("b2b_ab1", 8'({a[0], b[0]}), 8'(k / 2));
      tick();
    end
    chk("b2b_done1", 8'(dn[0]), 8'd1);
    results(0, 4'b1110);
    tick();
    chk("b2b_idle_busy", 8'(bz[0]), 8'd0);
    chk("b2b_idle_done", 8'(dn[0]), 8'd0);
    results(0, 4'b1110);
    tick();
    chk("b2b_busy2", 8'(bz[0]), 8'd1);
    chk("b2b_ab2", 8'({a[0], b[0]}), 8'd0);
    chk("b2b_cleared", 8'(ec[0]), 8'd0);
    st[0] = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("b2b_done_early", 8'(dn[0]), 8'd0);
    end
    tick();
    chk("b2b_done2", 8'(dn[0]), 8'd1);
    results(0, 4'b1110);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
